// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over windows of 2^WINDOW_BITS valid
// samples and presents each count on a valid/ready port with sticky overrun.
module bitstream_decoder #(
  parameter int WINDOW_BITS = 8,
  parameter bit CONTINUOUS  = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 bit_in,
  output logic [WINDOW_BITS:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  localparam logic [WINDOW_BITS-1:0] CNT_LAST = '1;
  localparam logic [WINDOW_BITS-1:0] CNT_ONE  = WINDOW_BITS'(1);

  logic [0:0]             state_q,     state_d;
  logic [WINDOW_BITS-1:0] cnt_q,       cnt_d;
  logic [WINDOW_BITS:0]   acc_q,       acc_d;
  logic [WINDOW_BITS:0]   out_count_q, out_count_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q,   overrun_d;
  logic [WINDOW_BITS:0]   acc_sum;

  // Cannot wrap: at most N-1 ones are held before the final sample adds one.
  assign acc_sum = acc_q + {{WINDOW_BITS{1'b0}}, bit_in};

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    // A pending result is consumed regardless of what the window is doing.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      cnt_d     = '0;
      acc_d     = '0;
      overrun_d = 1'b0;
      state_d   = (state_q == S_ACCUM && CONTINUOUS) ? S_ACCUM : S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_ACCUM;
      end
    end else if (in_valid) begin
      if (cnt_q == CNT_LAST) begin
        out_count_d = acc_sum;
        out_valid_d = 1'b1;
        // Overwriting an unconsumed result; a same-cycle transfer is not a loss.
        if (out_valid_q && !out_ready) begin
          overrun_d = 1'b1;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = CONTINUOUS ? S_ACCUM : S_IDLE;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_ACCUM);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Bench for bitstream_decoder: a continuous 256-sample instance and a 16-sample
// one-shot instance, checked against ones-counts taken from the stimulus queue.
module tb_bitstream_decoder;

  logic       clk = 1'b0;
  logic       n_rst, start, clear, in_valid, bit_in, out_ready;
  logic [8:0] out_count;
  logic       out_valid, busy, overrun;

  logic       s_start, s_in_valid, s_bit_in, s_out_ready;
  logic [4:0] s_out_count;
  logic       s_out_valid, s_busy, s_overrun;
  logic       s_clear = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit samp_q[$];

  always #5 clk = ~clk;

  bitstream_decoder #(.WINDOW_BITS(8), .CONTINUOUS(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .clear(clear),
    .in_valid(in_valid), .bit_in(bit_in), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  bitstream_decoder #(.WINDOW_BITS(4), .CONTINUOUS(1'b0)) dut_s (
    .clk(clk), .n_rst(n_rst), .start(s_start), .clear(s_clear),
    .in_valid(s_in_valid), .bit_in(s_bit_in), .out_count(s_out_count),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .busy(s_busy), .overrun(s_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a window's result is simply the number of ones queued for it.
  function automatic int count_ones(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(samp_q[i]);
    return s;
  endfunction

  task automatic make_window(input int k, input int n);
    bit arr[256];
    bit t;
    int j;
    for (int i = 0; i < n; i++) arr[i] = (i < k);
    for (int i = n - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = arr[i]; arr[i] = arr[j]; arr[j] = t;
    end
    for (int i = 0; i < n; i++) samp_q.push_back(arr[i]);
  endtask

  task automatic make_random(input int n);
    for (int i = 0; i < n; i++) samp_q.push_back(1'($urandom));
  endtask

  // mode 0: no stalls, 1: in_valid low every 3rd cycle, 2: random stalls.
  task automatic drive(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      while ((mode == 1 && cyc % 3 == 2) || (mode == 2 && $urandom_range(3, 0) == 0)) begin
        in_valid = 1'b0;
        bit_in   = 1'($urandom);
        tick();
        cyc++;
      end
      in_valid = 1'b1;
      bit_in   = samp_q.pop_front();
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    bit_in   = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b1; bit_in = 1'b1; out_ready = 1'b0;
    s_start = 1'b0; s_in_valid = 1'b0; s_bit_in = 1'b0; s_out_ready = 1'b0;
    tick(); tick();
    vectors++; if (out_count !== 9'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (s_out_valid !== 1'b0 || s_busy !== 1'b0) begin miscompares++; $display("FAIL reset_small: got valid=%b busy=%b expected 0 0", s_out_valid, s_busy); end
    n_rst = 1'b1; in_valid = 1'b0; bit_in = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: got busy=%b expected 0", busy); end
  endtask

  task automatic test_all_ones();
    int exp_c;
    out_ready = 1'b1;
    start = 1'b1; in_valid = 1'b1; bit_in = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_busy: got %b expected 1", busy); end
    for (int i = 0; i < 256; i++) samp_q.push_back(1'b1);
    exp_c = count_ones(256);
    drive(255, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_early: got valid=%b expected 0", out_valid); end
    drive(1, 0);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_c)) begin miscompares++; $display("FAIL ones_result: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp_c); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_consumed: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int exp0, exp1;
    for (int i = 0; i < 256; i++) samp_q.push_back(1'b0);
    exp0 = count_ones(256);
    for (int i = 0; i < 256; i++) samp_q.push_back(bit'(i % 2 == 0));
    exp1 = count_ones(512) - exp0;
    drive(256, 0);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp0)) begin miscompares++; $display("FAIL b2b_zeros: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp0); end
    drive(255, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got valid=%b expected 0", out_valid); end
    drive(1, 0);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp1)) begin miscompares++; $display("FAIL b2b_alt: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp1); end
  endtask

  task automatic test_stalls();
    int exp_c;
    cyc = 0;
    for (int i = 0; i < 256; i++) samp_q.push_back(bit'(i < 64));
    exp_c = count_ones(256);
    drive(255, 1);
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_early: got valid=%b expected 0", out_valid); end
    drive(1, 1);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_c)) begin miscompares++; $display("FAIL stall_result: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp_c); end
    for (int w = 0; w < 3; w++) begin
      make_random(256);
      exp_c = count_ones(256);
      drive(256, 2);
      vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_c)) begin miscompares++; $display("FAIL random_window%0d: got valid=%b count=%0d expected 1 %0d", w, out_valid, out_count, exp_c); end
    end
  endtask

  task automatic test_backpressure();
    int exp_a, exp_b;
    tick();
    out_ready = 1'b0;
    make_window(10, 256);
    exp_a = count_ones(256);
    drive(256, 2);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_a) || overrun !== 1'b0) begin miscompares++; $display("FAIL bp_first: got valid=%b count=%0d overrun=%b expected 1 %0d 0", out_valid, out_count, overrun, exp_a); end
    make_window(20, 256);
    exp_b = count_ones(256);
    drive(128, 2);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_a)) begin miscompares++; $display("FAIL bp_hold: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp_a); end
    drive(128, 2);
    vectors++; if (out_count !== 9'(exp_b) || overrun !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_overrun: got count=%0d overrun=%b valid=%b expected %0d 1 1", out_count, overrun, out_valid, exp_b); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0 || overrun !== 1'b1) begin miscompares++; $display("FAIL bp_sticky: got valid=%b overrun=%b expected 0 1", out_valid, overrun); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (overrun !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_clear: got overrun=%b busy=%b expected 0 1", overrun, busy); end

    out_ready = 1'b0;
    make_window(10, 256);
    exp_a = count_ones(256);
    drive(256, 0);
    make_window(20, 256);
    exp_b = count_ones(256);
    drive(255, 0);
    out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_a)) begin miscompares++; $display("FAIL bp_transfer_old: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp_a); end
    drive(1, 0);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_b) || overrun !== 1'b0) begin miscompares++; $display("FAIL bp_simul: got valid=%b count=%0d overrun=%b expected 1 %0d 0", out_valid, out_count, overrun, exp_b); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_clear_and_reset();
    int exp_c;
    out_ready = 1'b1;
    make_random(100);
    drive(100, 2);
    clear = 1'b1; in_valid = 1'b1; bit_in = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clear_no_result: got valid=%b expected 0", out_valid); end
    for (int i = 0; i < 256; i++) samp_q.push_back(1'b1);
    exp_c = count_ones(256);
    drive(255, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clear_early: got valid=%b expected 0", out_valid); end
    drive(1, 0);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_c) || overrun !== 1'b0) begin miscompares++; $display("FAIL clear_next: got valid=%b count=%0d overrun=%b expected 1 %0d 0", out_valid, out_count, overrun, exp_c); end

    make_random(100);
    drive(100, 2);
    n_rst = 1'b0; in_valid = 1'b1; bit_in = 1'b1; out_ready = 1'b0;
    tick();
    n_rst = 1'b1; in_valid = 1'b0;
    vectors++; if (out_count !== 9'd0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL midreset: got count=%0d valid=%b busy=%b overrun=%b expected 0 0 0 0", out_count, out_valid, busy, overrun); end
    for (int i = 0; i < 300; i++) samp_q.push_back(1'b1);
    drive(300, 0);
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_idle: got valid=%b busy=%b expected 0 0", out_valid, busy); end
    start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1;
    make_random(256);
    exp_c = count_ones(256);
    drive(256, 2);
    vectors++; if (out_valid !== 1'b1 || out_count !== 9'(exp_c)) begin miscompares++; $display("FAIL midreset_restart: got valid=%b count=%0d expected 1 %0d", out_valid, out_count, exp_c); end
  endtask

  task automatic test_oneshot_small();
    int exp_c;
    s_out_ready = 1'b0;
    s_start = 1'b1; s_in_valid = 1'b1; s_bit_in = 1'b1;
    tick();
    s_start = 1'b0; s_in_valid = 1'b0;
    vectors++; if (s_busy !== 1'b1) begin miscompares++; $display("FAIL small_busy: got %b expected 1", s_busy); end
    make_window(5, 16);
    exp_c = count_ones(16);
    for (int i = 0; i < 16; i++) begin
      s_in_valid = 1'b1; s_bit_in = samp_q.pop_front();
      tick();
    end
    s_in_valid = 1'b0;
    vectors++; if (s_out_valid !== 1'b1 || s_out_count !== 5'(exp_c) || s_busy !== 1'b0) begin miscompares++; $display("FAIL small_result: got valid=%b count=%0d busy=%b expected 1 %0d 0", s_out_valid, s_out_count, s_busy, exp_c); end
    for (int i = 0; i < 20; i++) begin
      s_in_valid = 1'b1; s_bit_in = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
    vectors++; if (s_out_count !== 5'(exp_c) || s_overrun !== 1'b0 || s_busy !== 1'b0) begin miscompares++; $display("FAIL small_idle: got count=%0d overrun=%b busy=%b expected %0d 0 0", s_out_count, s_overrun, s_busy, exp_c); end
    s_out_ready = 1'b1;
    tick();
    vectors++; if (s_out_valid !== 1'b0) begin miscompares++; $display("FAIL small_consume: got valid=%b expected 0", s_out_valid); end
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    make_random(16);
    exp_c = count_ones(16);
    for (int i = 0; i < 16; i++) begin
      s_in_valid = 1'b1; s_bit_in = samp_q.pop_front();
      tick();
    end
    s_in_valid = 1'b0;
    vectors++; if (s_out_valid !== 1'b1 || s_out_count !== 5'(exp_c) || s_busy !== 1'b0) begin miscompares++; $display("FAIL small_second: got valid=%b count=%0d busy=%b expected 1 %0d 0", s_out_valid, s_out_count, s_busy, exp_c); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_stalls();
    test_backpressure();
    test_clear_and_reset();
    test_oneshot_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
